nv_ram_rwsp_msk_param: RTL and testbench

- Parametrised next-generation single-port-read / single-port-write register-file RAM model for FPGA builds.
- Reads are two-stage: `re` captures the read address, and `ore` registers the output data.
- New over the fixed 16x16 generation:
  - arbitrary depth and width;
  - sub-word write mask;
  - optional write-to-read bypass;
  - post-reset zero-clear sweep FSM;
  - output-valid tracking.
- Sits under the NVDLA buffer/FIFO wrappers in place of the fixed-size models.

---
 rtl/nv_ram_pkg.sv | 35 +++
 rtl/nv_ram_msk_lane_merge.sv | 26 ++
 rtl/nv_ram_rwsp_msk_param.sv | 168 ++++++++++++++++
 tb/tb_nv_ram_rwsp_msk_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nv_ram_pkg.sv
// Shared definitions for the parametrised NVDLA register-file RAM family.
//   - nv_ram_state_e : sweep/run FSM encoding
//   - clog2          : address width helper (never returns less than 1)
//   - lane_width     : bits per write-mask lane
package nv_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } nv_ram_state_e;

  // Smallest n with 2**n >= value, clamped to 1 so a 2-entry RAM still has an address bit.
  function automatic int clog2(input int value);
    int r;
    r = 32'sd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 32'sd1;
      end else begin
        r = r;
      end
    end
    if (r < 32'sd1) begin
      r = 32'sd1;
    end else begin
      r = r;
    end
    return r;
  endfunction

  function automatic int lane_width(input int width, input int lanes);
    return width / lanes;
  endfunction

endpackage

// File: rtl/nv_ram_msk_lane_merge.sv
// Per-lane select between stored and incoming data.
//   old_data : current contents
//   new_data : candidate write data
//   mask     : lane k takes new_data when mask[k]=1, otherwise old_data
//   merged   : result
// Shared by the array write path and the output bypass path so both agree
// on lane boundaries.
module nv_ram_msk_lane_merge
  import nv_ram_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MASK_BITS = 4
) (
  input  logic [WIDTH-1:0]     old_data,
  input  logic [WIDTH-1:0]     new_data,
  input  logic [MASK_BITS-1:0] mask,
  output logic [WIDTH-1:0]     merged
);

  localparam int LW = lane_width(WIDTH, MASK_BITS);

  for (genvar k = 0; k < MASK_BITS; k++) begin : g_lane
    assign merged[k*LW +: LW] = mask[k] ? new_data[k*LW +: LW] : old_data[k*LW +: LW];
  end

endmodule

// File: rtl/nv_ram_rwsp_msk_param.sv
// Parametrised 1R/1W register-file RAM with sub-word write mask, optional
// write-to-read bypass, post-reset zero sweep and output-valid tracking.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   ra, re        : read address and its capture enable (stage 1)
//   ore           : output register enable (stage 2), drives dout/dout_vld
//   wa, we, wmask, di : write address, enable, per-lane mask, data
//   init_done     : high once the zero sweep has finished
//   pwrbus_ram_pd : legacy power-down bus, ignored
module nv_ram_rwsp_msk_param
  import nv_ram_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 32,
  parameter int MASK_BITS  = 4,
  parameter int BYPASS     = 1,
  parameter int INIT_CLEAR = 1,
  localparam int AW        = clog2(DEPTH)
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic [AW-1:0]        ra,
  input  logic                 re,
  input  logic                 ore,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_vld,
  input  logic [AW-1:0]        wa,
  input  logic                 we,
  input  logic [MASK_BITS-1:0] wmask,
  input  logic [WIDTH-1:0]     di,
  output logic                 init_done,
  input  logic [31:0]          pwrbus_ram_pd
);

  localparam logic [AW:0]   DEPTH_V  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam nv_ram_state_e RST_ST   = (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
  localparam logic          RST_DONE = (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
  localparam logic          BYP_EN   = (BYPASS != 0) ? 1'b1 : 1'b0;

  nv_ram_state_e        state_r;
  nv_ram_state_e        state_nxt_s;
  logic [AW-1:0]        cnt_r;
  logic [AW-1:0]        cnt_nxt_s;
  logic                 init_done_r;

  logic [WIDTH-1:0]     mem_r [DEPTH];

  logic [AW-1:0]        ra_d_r;
  logic                 rd_pend_r;
  logic [WIDTH-1:0]     dout_r;
  logic                 dout_vld_r;

  logic                 run_s;
  logic                 wa_ok_s;
  logic                 rd_ok_s;
  logic                 wr_en_s;
  logic                 byp_hit_s;
  logic [MASK_BITS-1:0] byp_mask_s;
  logic [WIDTH-1:0]     wr_old_s;
  logic [WIDTH-1:0]     wr_data_s;
  logic [WIDTH-1:0]     rd_raw_s;
  logic [WIDTH-1:0]     rd_data_s;
  logic                 unused_pd_s;

  assign unused_pd_s = ^pwrbus_ram_pd;

  // FSM state, sweep counter and init_done flag.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_r     <= RST_ST;
      cnt_r       <= '0;
      init_done_r <= RST_DONE;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      init_done_r <= (state_nxt_s == ST_RUN);
    end
  end

  // Next-state: sweep one entry per cycle, leave INIT after the last entry.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r + AW'(1);
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = RST_ST;
    endcase
  end

  // Address qualification and datapath selects. Out-of-range addresses read
  // as zero so nothing undefined reaches the output register.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    wa_ok_s    = ({1'b0, wa} < DEPTH_V);
    rd_ok_s    = ({1'b0, ra_d_r} < DEPTH_V);
    wr_en_s    = run_s & we & wa_ok_s;
    wr_old_s   = wa_ok_s ? mem_r[wa] : '0;
    rd_raw_s   = rd_ok_s ? mem_r[ra_d_r] : '0;
    // wr_en_s already implies wa < DEPTH, so a hit also implies ra_d < DEPTH.
    byp_hit_s  = BYP_EN & wr_en_s & (wa == ra_d_r);
    byp_mask_s = byp_hit_s ? wmask : '0;
  end

  nv_ram_msk_lane_merge #(
    .WIDTH     (WIDTH),
    .MASK_BITS (MASK_BITS)
  ) u_wr_merge (
    .old_data (wr_old_s),
    .new_data (di),
    .mask     (wmask),
    .merged   (wr_data_s)
  );

  nv_ram_msk_lane_merge #(
    .WIDTH     (WIDTH),
    .MASK_BITS (MASK_BITS)
  ) u_byp_merge (
    .old_data (rd_raw_s),
    .new_data (di),
    .mask     (byp_mask_s),
    .merged   (rd_data_s)
  );

  // Storage array: zero sweep during INIT, masked write in RUN. Not reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (state_r == ST_INIT) begin
      mem_r[cnt_r] <= '0;
    end else if (wr_en_s) begin
      mem_r[wa] <= wr_data_s;
    end
  end

  // Read address capture and output register; both frozen during INIT.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      ra_d_r     <= '0;
      rd_pend_r  <= 1'b0;
      dout_r     <= '0;
      dout_vld_r <= 1'b0;
    end else if (run_s) begin
      if (re) begin
        ra_d_r    <= ra;
        rd_pend_r <= 1'b1;
      end else if (ore) begin
        rd_pend_r <= 1'b0;
      end
      // ore samples the address captured before this edge, even when re
      // loads a new one on the same edge.
      if (ore) begin
        dout_r     <= rd_data_s;
        dout_vld_r <= rd_pend_r;
      end
    end
  end

  assign dout      = dout_r;
  assign dout_vld  = dout_vld_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_nv_ram_rwsp_msk_param.sv
module tb_nv_ram_rwsp_msk_param;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  ra, wa;
  logic        re, ore, we;
  logic [3:0]  wmask;
  logic [31:0] di, pd;

  logic [31:0] dout_b1, dout_b0, dout_d20;
  logic        vld_b1, vld_b0, vld_d20;
  logic        done_b1, done_b0, done_d20;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nv_ram_rwsp_msk_param #(.DEPTH(32), .BYPASS(1)) u_b1 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_b1), .dout_vld(vld_b1), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_done(done_b1), .pwrbus_ram_pd(pd));

  nv_ram_rwsp_msk_param #(.DEPTH(32), .BYPASS(0)) u_b0 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_b0), .dout_vld(vld_b0), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_done(done_b0), .pwrbus_ram_pd(pd));

  nv_ram_rwsp_msk_param #(.DEPTH(20), .BYPASS(1)) u_d20 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn), .ra(ra), .re(re), .ore(ore),
    .dout(dout_d20), .dout_vld(vld_d20), .wa(wa), .we(we), .wmask(wmask), .di(di),
    .init_done(done_d20), .pwrbus_ram_pd(pd));

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    re = 1'b0; ore = 1'b0; we = 1'b0; ra = 5'd0; wa = 5'd0; wmask = 4'h0; di = 32'h0;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1; wa = a; di = d; wmask = m;
    cyc();
    we = 1'b0; wmask = 4'h0;
  endtask

  task automatic do_read(input logic [4:0] a);
    re = 1'b1; ra = a;
    cyc();
    re = 1'b0; ore = 1'b1;
    cyc();
    ore = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    pd = 32'hFFFF_FFFF;
    rstn = 1'b0;
    cyc();
    cyc();
    total++; if (dout_b1 !== 32'h0) begin bad++; $display("FAIL rst_dout got=%h want=%h", dout_b1, 32'h0); end
    total++; if (vld_b1 !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b want=0", vld_b1); end
    total++; if (done_b1 !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done_b1); end
    rstn = 1'b1;
    // Traffic during the sweep must be ignored by the 32-entry instances.
    re = 1'b1; ra = 5'd3; ore = 1'b1; we = 1'b1; wa = 5'd3; di = 32'hFFFF_FFFF; wmask = 4'hF;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      total++; if (done_b1 !== (i >= 32)) begin bad++; $display("FAIL sweep_done32 cyc=%0d got=%b want=%b", i, done_b1, (i >= 32)); end
      total++; if (done_d20 !== (i >= 20)) begin bad++; $display("FAIL sweep_done20 cyc=%0d got=%b want=%b", i, done_d20, (i >= 20)); end
      total++; if ({vld_b1, dout_b1} !== 33'h0) begin bad++; $display("FAIL sweep_hold cyc=%0d got=%b/%h want=0/0", i, vld_b1, dout_b1); end
    end
    idle_inputs();
  endtask

  task automatic test_sweep_zero();
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a));
      total++; if ({vld_b1, dout_b1} !== {1'b1, 32'h0}) begin bad++; $display("FAIL zero_b1 a=%0d got=%b/%h want=1/00000000", a, vld_b1, dout_b1); end
      total++; if ({vld_b0, dout_b0} !== {1'b1, 32'h0}) begin bad++; $display("FAIL zero_b0 a=%0d got=%b/%h want=1/00000000", a, vld_b0, dout_b0); end
    end
  endtask

  task automatic test_midsweep_reset();
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) cyc();
    rstn = 1'b0;
    cyc();
    total++; if (done_b1 !== 1'b0) begin bad++; $display("FAIL mid_done got=%b want=0", done_b1); end
    rstn = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      cyc();
      total++; if (done_b1 !== (i >= 32)) begin bad++; $display("FAIL mid_restart cyc=%0d got=%b want=%b", i, done_b1, (i >= 32)); end
    end
  endtask

  task automatic test_masked_write();
    do_write(5'd5, 32'hAABB_CCDD, 4'hF);
    do_write(5'd5, 32'h1122_3344, 4'b0101);
    do_read(5'd5);
    total++; if (dout_b1 !== 32'hAA22_CC44) begin bad++; $display("FAIL mask_b1 got=%h want=AA22CC44", dout_b1); end
    total++; if (dout_b0 !== 32'hAA22_CC44) begin bad++; $display("FAIL mask_b0 got=%h want=AA22CC44", dout_b0); end
    do_write(5'd5, 32'hFFFF_FFFF, 4'h0);
    do_read(5'd5);
    total++; if (dout_b1 !== 32'hAA22_CC44) begin bad++; $display("FAIL mask_zero got=%h want=AA22CC44", dout_b1); end
  endtask

  task automatic test_bypass();
    re = 1'b1; ra = 5'd7;
    cyc();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd7; di = 32'hDEAD_BEEF; wmask = 4'hF;
    cyc();
    idle_inputs();
    total++; if (dout_b1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_full_b1 got=%h want=DEADBEEF", dout_b1); end
    total++; if (dout_b0 !== 32'h0) begin bad++; $display("FAIL byp_full_b0 got=%h want=00000000", dout_b0); end
    do_read(5'd7);
    total++; if (dout_b0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_after_b0 got=%h want=DEADBEEF", dout_b0); end

    re = 1'b1; ra = 5'd7;
    cyc();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd7; di = 32'h0123_4567; wmask = 4'b0011;
    cyc();
    idle_inputs();
    total++; if (dout_b1 !== 32'hDEAD_4567) begin bad++; $display("FAIL byp_part_b1 got=%h want=DEAD4567", dout_b1); end
    total++; if (dout_b0 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_part_b0 got=%h want=DEADBEEF", dout_b0); end

    // Address mismatch: no forwarding.
    re = 1'b1; ra = 5'd7;
    cyc();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd8; di = 32'h5555_5555; wmask = 4'hF;
    cyc();
    idle_inputs();
    total++; if (dout_b1 !== 32'hDEAD_4567) begin bad++; $display("FAIL byp_miss got=%h want=DEAD4567", dout_b1); end

    // Write on edge N is visible to ore on edge N+1.
    we = 1'b1; wa = 5'd9; di = 32'hCAFE_F00D; wmask = 4'hF; re = 1'b1; ra = 5'd9;
    cyc();
    idle_inputs(); ore = 1'b1;
    cyc();
    ore = 1'b0;
    total++; if (dout_b0 !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr_vis_b0 got=%h want=CAFEF00D", dout_b0); end
    total++; if (dout_b1 !== 32'hCAFE_F00D) begin bad++; $display("FAIL wr_vis_b1 got=%h want=CAFEF00D", dout_b1); end
  endtask

  task automatic test_back_to_back();
    do_write(5'd1, 32'h1, 4'hF);
    do_write(5'd2, 32'h2, 4'hF);
    re = 1'b1; ra = 5'd1;
    cyc();
    re = 1'b1; ra = 5'd2; ore = 1'b1;
    cyc();
    total++; if ({vld_b1, dout_b1} !== {1'b1, 32'h1}) begin bad++; $display("FAIL b2b_first got=%b/%h want=1/00000001", vld_b1, dout_b1); end
    re = 1'b0;
    cyc();
    total++; if ({vld_b1, dout_b1} !== {1'b1, 32'h2}) begin bad++; $display("FAIL b2b_second got=%b/%h want=1/00000002", vld_b1, dout_b1); end
    cyc();
    total++; if (vld_b1 !== 1'b0) begin bad++; $display("FAIL b2b_novld got=%b want=0", vld_b1); end
    ore = 1'b0; ra = 5'd5;
    cyc();
    total++; if ({vld_b1, dout_b1} !== {1'b0, 32'h2}) begin bad++; $display("FAIL b2b_hold got=%b/%h want=0/00000002", vld_b1, dout_b1); end
  endtask

  task automatic test_depth20();
    do_read(5'd25);
    total++; if ({vld_d20, dout_d20} !== {1'b1, 32'h0}) begin bad++; $display("FAIL d20_oor_rd got=%b/%h want=1/00000000", vld_d20, dout_d20); end
    re = 1'b1; ra = 5'd25;
    cyc();
    re = 1'b0; ore = 1'b1; we = 1'b1; wa = 5'd25; di = 32'hDEAD_BEEF; wmask = 4'hF;
    cyc();
    idle_inputs();
    total++; if (dout_d20 !== 32'h0) begin bad++; $display("FAIL d20_oor_byp got=%h want=00000000", dout_d20); end
    total++; if (dout_b1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL d32_byp25 got=%h want=DEADBEEF", dout_b1); end
    do_read(5'd25);
    total++; if (dout_d20 !== 32'h0) begin bad++; $display("FAIL d20_oor_wr got=%h want=00000000", dout_d20); end
    total++; if (dout_b1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL d32_wr25 got=%h want=DEADBEEF", dout_b1); end
    do_write(5'd19, 32'h1357_9BDF, 4'hF);
    do_read(5'd19);
    total++; if ({vld_d20, dout_d20} !== {1'b1, 32'h1357_9BDF}) begin bad++; $display("FAIL d20_last got=%b/%h want=1/13579BDF", vld_d20, dout_d20); end
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    pd = 32'h0;
    @(negedge clk);
    test_reset();
    test_sweep_zero();
    test_midsweep_reset();
    test_masked_write();
    test_bypass();
    test_back_to_back();
    test_depth20();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
